// File: rtl/bcd_conv_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_conv_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_e;

  // Bits needed to hold any value below 10^digits.
  function automatic int unsigned clog2_pow10(input int unsigned digits);
    longint unsigned pow = 64'd1;
    longint unsigned one = 64'd1;
    int unsigned     w   = 0;
    for (int unsigned i = 0; i < digits; i++) begin
      pow = pow * 64'd10;
    end
    while ((one << w) < pow) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational acc*10 + digit step plus a flag for a non-decimal digit.
module bcd_digit_mac
  import bcd_conv_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BIN_W+3:0]       sum_o,
  output logic                   bad_o
);

  logic [BIN_W+3:0] acc_ext;
  logic [BIN_W+3:0] digit_ext;

  always_comb begin
    acc_ext   = {4'b0000, acc_i};
    digit_ext = {{BIN_W{1'b0}}, digit_i};
    sum_o     = (acc_ext << 3) + (acc_ext << 1) + digit_ext;
    bad_o     = (digit_i > 4'd9);
  end

endmodule

// File: rtl/bcd_binary_seq_converter.sv
// Multi-cycle BCD-to-binary converter: one digit per clock, MSD first, valid/ready on both sides.
module bcd_binary_seq_converter
  import bcd_conv_pkg::*;
#(
  parameter int unsigned  DIGITS = 4,
  localparam int unsigned BIN_W  = clog2_pow10(DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              out_bin,
  output logic                          out_err
);

  localparam int unsigned CntW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned WordW = BCD_DIGIT_W * DIGITS;

  conv_state_e      state_q, state_d;
  logic [WordW-1:0] digits_q, digits_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [BIN_W-1:0] out_bin_q, out_bin_d;
  logic             out_err_q, out_err_d;

  logic [BIN_W+3:0] mac_sum;
  logic             mac_bad;
  logic             unused_mac_hi;

  bcd_digit_mac #(
    .BIN_W(BIN_W)
  ) u_mac (
    .acc_i  (acc_q),
    .digit_i(digits_q[WordW-1 -: BCD_DIGIT_W]),
    .sum_o  (mac_sum),
    .bad_o  (mac_bad)
  );

  // Upper bits only carry for invalid digits, where the result is discarded anyway.
  assign unused_mac_hi = ^mac_sum[BIN_W+3:BIN_W];

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_err_d   = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          digits_d = in_bcd;
          acc_d    = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = CONV;
        end
      end
      CONV: begin
        acc_d    = mac_sum[BIN_W-1:0];
        err_d    = err_q | mac_bad;
        digits_d = digits_q << BCD_DIGIT_W;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIGITS - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_bin_d   = err_d ? '0 : acc_d;
          out_err_d   = err_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      digits_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_binary_seq_converter.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop them on each output handshake.
module tb_bcd_binary_seq_converter;

  typedef struct {
    int bin;
    int err;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_err4;
  logic [15:0] in_bcd4 = '0;
  logic [13:0] out_bin4;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, out_err2;
  logic [7:0]  in_bcd2 = '0;
  logic [6:0]  out_bin2;

  exp_t q4[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_binary_seq_converter #(.DIGITS(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .in_bcd   (in_bcd4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .out_bin  (out_bin4),
    .out_err  (out_err4)
  );

  bcd_binary_seq_converter #(.DIGITS(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .in_bcd   (in_bcd2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .out_bin  (out_bin2),
    .out_err  (out_err2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic send4(input logic [15:0] b, input int eb, input int ee, input bit push,
                       output int acc);
    int n = 0;
    acc = -1;
    in_valid4 = 1'b1;
    in_bcd4   = b;
    forever begin
      @(negedge clk);
      if (in_ready4) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout4", 0, 1);
        in_valid4 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid4 = 1'b0;
    if (push) q4.push_back('{eb, ee, acc});
  endtask

  task automatic send2(input logic [7:0] b, input int eb, input int ee);
    int n = 0;
    in_valid2 = 1'b1;
    in_bcd2   = b;
    forever begin
      @(negedge clk);
      if (in_ready2) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout2", 0, 1);
        in_valid2 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    q2.push_back('{eb, ee, cyc});
  endtask

  task automatic wait_valid4();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid4) return;
    end
    chk("valid_timeout4", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (q4.size() == 0 && q2.size() == 0) begin
        #1;
        return;
      end
    end
    chk("drain_timeout", 0, 1);
    #1;
  endtask

  initial begin : mon4
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid4 && !prev && q4.size() > 0) chk("latency4", cyc - q4[0].acc, 4);
        if (out_valid4 && out_ready4) begin
          if (q4.size() == 0) begin
            chk("unexpected_out4", 1, 0);
          end else begin
            e = q4.pop_front();
            chk("bin4", int'(out_bin4), e.bin);
            chk("err4", int'(out_err4), e.err);
          end
        end
        prev = out_valid4;
      end
    end
  end

  initial begin : mon2
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid2 && !prev && q2.size() > 0) chk("latency2", cyc - q2[0].acc, 2);
        if (out_valid2 && out_ready2) begin
          if (q2.size() == 0) begin
            chk("unexpected_out2", 1, 0);
          end else begin
            e = q2.pop_front();
            chk("bin2", int'(out_bin2), e.bin);
            chk("err2", int'(out_err2), e.err);
          end
        end
        prev = out_valid2;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected $finish)");
    $fatal(1);
  end

  initial begin : stim
    int a0, a1, a2, a3, dummy;

    #23;
    chk("rst_out_valid", int'(out_valid4), 0);
    chk("rst_out_bin", int'(out_bin4), 0);
    chk("rst_out_err", int'(out_err4), 0);
    chk("rst_in_ready", int'(in_ready4), 1);
    chk("rst_in_ready2", int'(in_ready2), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Max 4-digit value and 2-digit vectors.
    send4(16'h9999, 9999, 0, 1'b1, dummy);
    drain();
    send2(8'h99, 99, 0);
    send2(8'h00, 0, 0);
    send2(8'h07, 7, 0);
    drain();

    // Invalid digit, then a clean word to prove err is per-word.
    send4(16'h12A4, 0, 1, 1'b1, dummy);
    send4(16'h0042, 42, 0, 1'b1, dummy);
    drain();

    // Output back-pressure: outputs hold, no new accept.
    out_ready4 = 1'b0;
    send4(16'h1234, 1234, 0, 1'b1, dummy);
    wait_valid4();
    @(posedge clk);
    #1;
    in_valid4 = 1'b1;
    in_bcd4   = 16'h9999;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid4), 1);
      chk("hold_bin", int'(out_bin4), 1234);
      chk("hold_err", int'(out_err4), 0);
      chk("hold_in_ready", int'(in_ready4), 0);
    end
    @(posedge clk);
    #1;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    drain();
    repeat (8) @(negedge clk);
    chk("no_stray_accept", int'(out_valid4), 0);

    // Asynchronous reset in the second CONV cycle.
    @(posedge clk);
    #1;
    send4(16'h1234, 0, 0, 1'b0, dummy);
    @(posedge clk);
    #3;
    chk("conv_in_ready_pre", int'(in_ready4), 0);
    rst_n = 1'b0;
    #1;
    chk("conv_rst_valid", int'(out_valid4), 0);
    chk("conv_rst_in_ready", int'(in_ready4), 1);
    chk("conv_rst_bin", int'(out_bin4), 0);
    chk("conv_rst_err", int'(out_err4), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send4(16'h0500, 500, 0, 1'b1, dummy);
    drain();

    // Asynchronous reset while holding a result in DONE.
    out_ready4 = 1'b0;
    send4(16'h0777, 0, 0, 1'b0, dummy);
    wait_valid4();
    chk("done_pre_bin", int'(out_bin4), 777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("done_rst_valid", int'(out_valid4), 0);
    chk("done_rst_bin", int'(out_bin4), 0);
    chk("done_rst_err", int'(out_err4), 0);
    chk("done_rst_in_ready", int'(in_ready4), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready4 = 1'b1;

    // Back-to-back stream at peak throughput.
    send4(16'h0000, 0, 0, 1'b1, a0);
    send4(16'h0001, 1, 0, 1'b1, a1);
    send4(16'h9998, 9998, 0, 1'b1, a2);
    send4(16'h5050, 5050, 0, 1'b1, a3);
    chk("spacing01", a1 - a0, 6);
    chk("spacing12", a2 - a1, 6);
    chk("spacing23", a3 - a2, 6);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_binary_seq_converter.md
# bcd_binary_seq_converter

Parametrised, multi-cycle BCD-to-binary converter. It is the successor of the team's fixed 2-digit combinational converter. It takes a DIGITS-digit packed BCD word over a valid/ready handshake and converts it MSD-first, one digit per clock, using multiply-by-10-and-accumulate. It returns the binary result and an invalid-digit flag over a second valid/ready handshake. It sits between the BCD keypad/display-side datapath and the binary arithmetic units.

## Interface
- DIGITS, 4, number of BCD digits in the input word (1..9).
- BIN_W, derived (not overridable), ceil(log2(10^DIGITS)); equals 14 for DIGITS=4 and 7 for DIGITS=2.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  converter can accept a word.
- in_bcd  input  4*DIGITS  packed BCD; digit i occupies [4i+3:4i]; digit DIGITS-1 is the MSD.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_bin  output  BIN_W  binary result.
- out_err  output  1  at least one digit was greater than 9.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: latch in_bcd into the digit shift register, clear acc and err, set cnt=0, go to CONV.
- **CONV**
  - in_ready=0; in_valid is ignored.
  - Each cycle: take the top digit d; update acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d.
  - If d>9, set the sticky err flag.
  - Shift the digit register left by 4 and increment cnt.
  - When cnt==DIGITS-1, go to DONE.
- **DONE**
  - out_valid=1.
  - out_bin = err ? 0 : acc.
  - out_err = err.
  - Outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE.
- **Arithmetic**
  - The intermediate acc*10+d is BIN_W+4 bits wide and is truncated to BIN_W.
  - Truncation never loses bits for valid inputs, because every partial result is below 10^DIGITS.
  - With invalid digits the accumulated value is unspecified internally; out_bin is forced to 0.
- **Reset** (asynchronous, at any time including mid-CONV or DONE):
  - FSM returns to IDLE and discards any in-flight word.
  - Reset values: out_valid=0, out_bin=0, out_err=0, in_ready=1, acc=0, cnt=0.

## Timing
- The input handshake completes at edge k. Digits are consumed at edges k+1 .. k+DIGITS.
- out_valid is high from edge k+DIGITS, so latency is DIGITS cycles.
- The output handshake at edge m returns the FSM to IDLE. in_ready is high from m.
- The next accept is at m+1 at earliest, giving a peak throughput of one word per DIGITS+2 cycles.
- in_ready is a decode of the state register only. It has no combinational path from in_valid or out_ready.
- out_valid, out_bin and out_err are registered outputs.

## Structure
- Shared package `bcd_conv_pkg`:
  - state enum {IDLE, CONV, DONE}.
  - function clog2_pow10(digits), which returns BIN_W.
  - constant BCD_DIGIT_W=4.
- Sub-module `bcd_digit_mac`: purely combinational, computes acc*10+d and a digit>9 flag, parametrised by BIN_W. It is instantiated once.
- The top level holds the FSM, the digit shift register, cnt (clog2(DIGITS) bits, minimum 1), acc and err.

## Test plan
- DIGITS=4, in_bcd=16'h9999 -> out_bin=14'd9999 (0x270F), out_err=0; out_valid rises exactly 4 cycles after accept.
- DIGITS=2, in_bcd=8'h99 -> out_bin=7'd99; in_bcd=8'h00 -> out_bin=0; in_bcd=8'h07 -> out_bin=7.
- DIGITS=4, in_bcd=16'h12A4 -> out_err=1, out_bin=0.
  - Follow with 16'h0042 -> out_err=0, out_bin=42, proving err is cleared per word.
- DIGITS=4, in_bcd=16'h1234, out_ready held low for 5 cycles -> out_valid, out_bin=1234 and out_err stay stable; in_ready stays 0 and a new in_valid is not accepted.
- Assert rst_n=0 asynchronously (mid-cycle) during the 2nd CONV cycle -> outputs go to reset values immediately; after release, a word of 16'h0500 converts to 500 with no residue.
- Back-to-back stream of 0000, 0001, 9998, 5050 with in_valid and out_ready held high -> results 0, 1, 9998, 5050 in order; accepts spaced DIGITS+2 cycles apart.
